// File: rtl/ram_sync_clr_pkg.sv
// Shared types and helpers for the clearable synchronous RAM.
package ram_pkg;

    // Sequencer states: CLEAR fills the array, IDLE serves reads and writes.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // Read-during-write behaviour selectors.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // True when the clear pointer sits on the last word of the array.
    function automatic logic clr_done(input int unsigned clr_addr, input int unsigned depth);
        return clr_addr == depth - 1;
    endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: owns the CLEAR/IDLE FSM and the clear pointer, and muxes
// the array write port between the sequencer and the user.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int                DATA_W    = 4,
    parameter int                ADDR_W    = 5,
    parameter int                DEPTH     = 32,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_write,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_rd_en,
    output logic              o_rd_oob
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              w_busy;
    logic              w_in_range;
    logic              w_done;

    assign w_busy     = (r_state == CLEAR);
    assign w_in_range = (32'(i_addr) < DEPTH);
    assign w_done     = clr_done(32'(r_clr_addr), DEPTH);

    // FSM and clear pointer; Clear restarts the fill from word 0 in either state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else if (i_clear) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else if (r_state == CLEAR) begin
            if (w_done) begin
                r_state    <= IDLE;
                r_clr_addr <= '0;
            end else begin
                r_clr_addr <= r_clr_addr + ADDR_W'(1);
            end
        end
    end

    // Write-port mux: the sequencer owns the port while busy; user writes
    // are dropped when Clear is raised or the address is beyond DEPTH.
    always_comb begin
        o_we    = 1'b0;
        o_waddr = i_addr;
        o_wdata = i_wdata;
        if (w_busy) begin
            o_we    = 1'b1;
            o_waddr = r_clr_addr;
            o_wdata = CLEAR_VAL;
        end else begin
            o_we = i_write && !i_clear && w_in_range;
        end
    end

    assign o_rd_en    = !w_busy && !i_clear && i_read;
    assign o_rd_oob   = !w_in_range;
    assign o_busy     = w_busy;
    assign o_clr_addr = r_clr_addr;

endmodule

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with registered read, valid strobe,
// selectable read-during-write and a hardware clear sequencer.
module ram_sync_clr
    import ram_pkg::*;
#(
    parameter int                DATA_W    = 4,
    parameter int                ADDR_W    = 5,
    parameter int                DEPTH     = 32,
    parameter int                RDW_MODE  = RDW_OLD,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Write,
    input  logic              Read,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Clear,
    output logic [DATA_W-1:0] DataOut,
    output logic              Valid,
    output logic              Busy,
    output logic [ADDR_W-1:0] ClrAddr
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_rd_en;
    logic              w_rd_oob;

    ram_clr_seq #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .CLEAR_VAL (CLEAR_VAL)
    ) u_seq (
        .i_clk      (Clock),
        .i_rst_n    (Resetn),
        .i_clear    (Clear),
        .i_write    (Write),
        .i_read     (Read),
        .i_addr     (Address),
        .i_wdata    (DataIn),
        .o_busy     (Busy),
        .o_clr_addr (ClrAddr),
        .o_we       (w_we),
        .o_waddr    (w_waddr),
        .o_wdata    (w_wdata),
        .o_rd_en    (w_rd_en),
        .o_rd_oob   (w_rd_oob)
    );

    // Array write; contents are initialised by the clear sequencer, not by reset.
    always_ff @(posedge Clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Registered read: out-of-range reads return CLEAR_VAL. A same-cycle user
    // write always targets Address, so write-first just forwards the write data.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_en;
            if (w_rd_en) begin
                if (w_rd_oob) begin
                    r_dout <= CLEAR_VAL;
                end else if (RDW_MODE == RDW_NEW && w_we) begin
                    r_dout <= w_wdata;
                end else begin
                    r_dout <= r_mem[Address];
                end
            end
        end
    end

    assign DataOut = r_dout;
    assign Valid   = r_valid;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed bench for ram_sync_clr: three instances cover the default
// configuration, write-first with a non-zero clear value, and a short array.
module tb_ram_sync_clr;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [4:0] addr;
    logic [3:0] din;
    logic       exp_v;
    logic [3:0] exp_d;
  } vec_t;

  // clk/rst block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr    [3];
  logic       rd    [3];
  logic       clr   [3];
  logic [4:0] addr  [3];
  logic [3:0] din   [3];
  logic [3:0] dout  [3];
  logic       valid [3];
  logic       busy  [3];
  logic [4:0] caddr [3];

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[$];

  // Instance 0: defaults (32x4, old-data, clear to 0)
  ram_sync_clr #(.DATA_W(4), .ADDR_W(5), .DEPTH(32), .RDW_MODE(0), .CLEAR_VAL(4'h0)) dut0 (
    .Clock(clk), .Resetn(rst_n), .Write(wr[0]), .Read(rd[0]), .Address(addr[0]),
    .DataIn(din[0]), .Clear(clr[0]), .DataOut(dout[0]), .Valid(valid[0]),
    .Busy(busy[0]), .ClrAddr(caddr[0]));

  // Instance 1: write-first, clear to 0x6
  ram_sync_clr #(.DATA_W(4), .ADDR_W(5), .DEPTH(32), .RDW_MODE(1), .CLEAR_VAL(4'h6)) dut1 (
    .Clock(clk), .Resetn(rst_n), .Write(wr[1]), .Read(rd[1]), .Address(addr[1]),
    .DataIn(din[1]), .Clear(clr[1]), .DataOut(dout[1]), .Valid(valid[1]),
    .Busy(busy[1]), .ClrAddr(caddr[1]));

  // Instance 2: 20 words, clear to 0xB
  ram_sync_clr #(.DATA_W(4), .ADDR_W(5), .DEPTH(20), .RDW_MODE(0), .CLEAR_VAL(4'hB)) dut2 (
    .Clock(clk), .Resetn(rst_n), .Write(wr[2]), .Read(rd[2]), .Address(addr[2]),
    .DataIn(din[2]), .Clear(clr[2]), .DataOut(dout[2]), .Valid(valid[2]),
    .Busy(busy[2]), .ClrAddr(caddr[2]));

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic c, input logic [4:0] a,
                              input logic [3:0] d, input logic ev, input logic [3:0] ed);
    vec_t v;
    v.wr = w; v.rd = r; v.clr = c; v.addr = a; v.din = d; v.exp_v = ev; v.exp_d = ed;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input int k, input logic w, input logic r, input logic c,
                       input logic [4:0] a, input logic [3:0] d);
    wr[k] = w; rd[k] = r; clr[k] = c; addr[k] = a; din[k] = d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset for a cycle, check reset values on instance k, release at a negedge.
  task automatic reset_all(input int k);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_dout", 32'(dout[k]), 32'h0);
    chk("reset_valid", 32'(valid[k]), 32'h0);
    chk("reset_busy", 32'(busy[k]), 32'h1);
    chk("reset_clraddr", 32'(caddr[k]), 32'h0);
    rst_n = 1'b1;
  endtask

  // Follow a clear sequence that has just (re)started; optionally attempt a
  // write/read at step 'poke' (to address 3, data 1) which must be ignored.
  task automatic wait_clear(input int k, input int depth, input int poke);
    chk("clr_start_busy", 32'(busy[k]), 32'h1);
    chk("clr_start_addr", 32'(caddr[k]), 32'h0);
    for (int i = 1; i <= depth; i++) begin
      if (i == poke) drive(k, 1'b1, 1'b1, 1'b0, 5'd3, 4'h1);
      else drive(k, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);
      step();
      if (i < depth) begin
        chk("clr_busy", 32'(busy[k]), 32'h1);
        chk("clr_addr", 32'(caddr[k]), 32'(i));
        chk("clr_valid", 32'(valid[k]), 32'h0);
      end else begin
        chk("clr_end_busy", 32'(busy[k]), 32'h0);
        chk("clr_end_addr", 32'(caddr[k]), 32'h0);
      end
    end
    drive(k, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);
  endtask

  task automatic run_tbl(input int k);
    foreach (tbl[i]) begin
      drive(k, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].addr, tbl[i].din);
      step();
      chk($sformatf("vec%0d_%0d_valid", k, i), 32'(valid[k]), 32'(tbl[i].exp_v));
      chk($sformatf("vec%0d_%0d_dout", k, i), 32'(dout[k]), 32'(tbl[i].exp_d));
      chk($sformatf("vec%0d_%0d_busy", k, i), 32'(busy[k]), 32'h0);
    end
    drive(k, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);
    tbl.delete();
  endtask

  task automatic read_chk(input int k, input logic [4:0] a, input logic [3:0] exp, input string name);
    drive(k, 1'b0, 1'b1, 1'b0, a, 4'h0);
    step();
    chk({name, "_valid"}, 32'(valid[k]), 32'h1);
    chk({name, "_dout"}, 32'(dout[k]), 32'(exp));
    drive(k, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);
    @(negedge clk);

    // ---------- Instance 0: defaults ----------
    reset_all(0);
    wait_clear(0, 32, 0);
    tbl.push_back(mk(0, 1, 0, 5'd0,  4'h0, 1, 4'h0));
    tbl.push_back(mk(0, 1, 0, 5'd17, 4'h0, 1, 4'h0));
    tbl.push_back(mk(0, 1, 0, 5'd31, 4'h0, 1, 4'h0));
    tbl.push_back(mk(1, 0, 0, 5'd5,  4'hA, 0, 4'h0));
    tbl.push_back(mk(0, 1, 0, 5'd5,  4'h0, 1, 4'hA));
    tbl.push_back(mk(0, 0, 0, 5'd5,  4'h0, 0, 4'hA));
    tbl.push_back(mk(1, 0, 0, 5'd9,  4'h3, 0, 4'hA));
    tbl.push_back(mk(1, 1, 0, 5'd9,  4'hC, 1, 4'h3));
    tbl.push_back(mk(0, 1, 0, 5'd9,  4'h0, 1, 4'hC));
    tbl.push_back(mk(0, 1, 0, 5'd5,  4'h0, 1, 4'hA));
    tbl.push_back(mk(1, 0, 0, 5'd31, 4'hF, 0, 4'hA));
    tbl.push_back(mk(0, 1, 0, 5'd31, 4'h0, 1, 4'hF));
    run_tbl(0);

    // Clear beats a same-cycle read: read dropped, DataOut holds.
    drive(0, 1'b0, 1'b1, 1'b1, 5'd5, 4'h0);
    step();
    chk("clr_prio_valid", 32'(valid[0]), 32'h0);
    chk("clr_prio_dout", 32'(dout[0]), 32'hF);
    chk("clr_prio_busy", 32'(busy[0]), 32'h1);
    drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);
    for (int i = 0; i < 12; i++) step();
    chk("restart_pre_addr", 32'(caddr[0]), 32'd12);
    drive(0, 1'b0, 1'b0, 1'b1, 5'd0, 4'h0);
    step();
    wait_clear(0, 32, 0);
    read_chk(0, 5'd5, 4'h0, "after_clear5");

    // Reset in the middle of a clear sequence.
    drive(0, 1'b1, 1'b0, 1'b0, 5'd3, 4'h9);
    step();
    read_chk(0, 5'd3, 4'h9, "pre_reset3");
    drive(0, 1'b0, 1'b0, 1'b1, 5'd0, 4'h0);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);
    for (int i = 0; i < 7; i++) step();
    chk("midclr_addr", 32'(caddr[0]), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 32'(dout[0]), 32'h0);
    chk("async_rst_valid", 32'(valid[0]), 32'h0);
    chk("async_rst_addr", 32'(caddr[0]), 32'h0);
    chk("async_rst_busy", 32'(busy[0]), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(0, 32, 0);
    read_chk(0, 5'd3, 4'h0, "post_reset3");

    // ---------- Instance 1: write-first, CLEAR_VAL=6 ----------
    reset_all(1);
    wait_clear(1, 32, 0);
    tbl.push_back(mk(0, 1, 0, 5'd0,  4'h0, 1, 4'h6));
    tbl.push_back(mk(1, 0, 0, 5'd9,  4'h3, 0, 4'h6));
    tbl.push_back(mk(1, 1, 0, 5'd9,  4'hC, 1, 4'hC));
    tbl.push_back(mk(0, 1, 0, 5'd9,  4'h0, 1, 4'hC));
    tbl.push_back(mk(0, 1, 0, 5'd10, 4'h0, 1, 4'h6));
    run_tbl(1);

    for (int a = 0; a < 32; a++) begin
      drive(1, 1'b1, 1'b0, 1'b0, 5'(a), 4'(a) ^ 4'hF);
      step();
    end
    read_chk(1, 5'd4, 4'hB, "fill4");
    read_chk(1, 5'd31, 4'h0, "fill31");
    drive(1, 1'b0, 1'b0, 1'b1, 5'd0, 4'h0);
    step();
    wait_clear(1, 32, 20);
    for (int a = 0; a < 32; a++) begin
      drive(1, 1'b0, 1'b1, 1'b0, 5'(a), 4'h0);
      step();
      chk($sformatf("cleared%0d_valid", a), 32'(valid[1]), 32'h1);
      chk($sformatf("cleared%0d_dout", a), 32'(dout[1]), 32'h6);
    end
    drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);

    // ---------- Instance 2: DEPTH=20, CLEAR_VAL=B ----------
    reset_all(2);
    wait_clear(2, 20, 0);
    tbl.push_back(mk(1, 0, 0, 5'd25, 4'h5, 0, 4'h0));
    tbl.push_back(mk(0, 1, 0, 5'd25, 4'h0, 1, 4'hB));
    tbl.push_back(mk(1, 0, 0, 5'd19, 4'h9, 0, 4'hB));
    tbl.push_back(mk(0, 1, 0, 5'd19, 4'h0, 1, 4'h9));
    tbl.push_back(mk(0, 1, 0, 5'd25, 4'h0, 1, 4'hB));
    tbl.push_back(mk(0, 1, 0, 5'd5,  4'h0, 1, 4'hB));
    tbl.push_back(mk(0, 1, 0, 5'd19, 4'h0, 1, 4'h9));
    run_tbl(2);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_sync_clr.md
Name: ram_sync_clr

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 32x4 board RAM.
- Adds:
  - configurable width and depth
  - registered read data with a read-enable and valid strobe
  - selectable read-during-write mode
  - a hardware clear sequencer that fills the array with a constant after reset or on request
- Sits between the board switch/key front-end and the hex7seg display digits; also usable as scratch storage by later calculator datapaths.

Parameters:
- DATA_W, 4, data word width in bits (1..32)
- ADDR_W, 5, address width in bits (1..10)
- DEPTH, 32, number of words; 1 <= DEPTH <= 2**ADDR_W
- RDW_MODE, 0, read-during-write to same address: 0 = return old data, 1 = return new data (write-first)
- CLEAR_VAL, 0, DATA_W-bit value written to every word by the clear sequencer

Ports:
- Clock  input  1  rising-edge clock
- Resetn  input  1  asynchronous active-low reset
- Write  input  1  write enable, sampled at rising edge
- Read  input  1  read enable, sampled at rising edge
- Address  input  ADDR_W  word address for read and write
- DataIn  input  DATA_W  write data
- Clear  input  1  request full-array clear (level, sampled at rising edge)
- DataOut  output  DATA_W  registered read data
- Valid  output  1  one-cycle strobe: DataOut updated this cycle
- Busy  output  1  clear sequencer active; Read/Write ignored while high
- ClrAddr  output  ADDR_W  current clear pointer (debug / LEDR)

Behaviour:
- Reset (Resetn=0, asynchronous):
  - DataOut=0, Valid=0, ClrAddr=0, state=CLEAR, Busy=1.
  - Array contents are not reset directly; the clear sequencer initialises them.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Each cycle writes CLEAR_VAL to mem[ClrAddr], then ClrAddr increments.
  - When ClrAddr == DEPTH-1 the last word is written; next state is IDLE and ClrAddr returns to 0.
  - Duration is exactly DEPTH cycles after reset release.
  - Busy=1 throughout. Write and Read are ignored. Valid=0 and DataOut holds.
  - Clear asserted while in CLEAR restarts the sequence: ClrAddr returns to 0 on that edge.
- IDLE state:
  - Busy=0.
  - Clear=1 at an edge moves to CLEAR with ClrAddr=0. Clear takes priority over Read/Write in the same cycle, and that cycle's Read/Write are dropped.
- Write (IDLE, Write=1): mem[Address] <= DataIn at the edge.
- Read (IDLE, Read=1):
  - DataOut <= mem[Address] at the edge; Valid=1 for the following cycle only.
  - Latency is 1 clock from the sampling edge.
  - With Read=0, DataOut holds its last value and Valid=0.
- Simultaneous Read and Write to the same address:
  - RDW_MODE=0: DataOut gets the pre-write contents.
  - RDW_MODE=1: DataOut gets DataIn.
  - Different addresses: independent, no interaction.
- Out-of-range address (Address >= DEPTH, possible only when DEPTH < 2**ADDR_W):
  - Write is dropped and the array is unchanged.
  - Read returns CLEAR_VAL with Valid=1.
- Back-to-back reads every cycle: Valid stays high continuously and DataOut tracks each address with 1-cycle latency.
- Reset asserted mid-clear or mid-operation: immediately returns to the reset values and the clear restarts from 0 after release.
- No combinational path from any input to any output.

Decomposition:
- Package ram_pkg holds:
  - state enum {CLEAR, IDLE}
  - RDW_OLD=0 and RDW_NEW=1 constants
  - a function computing the clear-done compare (ClrAddr == DEPTH-1)
- One natural sub-module: ram_clr_seq, which owns the FSM, ClrAddr counter and Busy, and drives the internal write port mux. Main module holds the array, read register and RDW logic.

Test Plan:
- Reset release, defaults (DATA_W=4, ADDR_W=5, DEPTH=32) -> Busy=1 for exactly 32 cycles, then 0; ClrAddr steps 0..31. Read of addresses 0, 17 and 31 then gives DataOut=0 with Valid=1 one cycle after each Read.
- Write 0xA to address 5, then Read address 5 next cycle -> DataOut=0xA and Valid=1 one cycle later. Valid=0 on the following idle cycle, and DataOut holds 0xA.
- Address 9 holds 0x3; same-cycle Write 0xC + Read at address 9 -> RDW_MODE=0 gives DataOut=0x3, RDW_MODE=1 gives DataOut=0xC. A subsequent plain read returns 0xC in both modes.
- Fill addresses 0..31 with addr^0xF, assert Clear for 1 cycle with CLEAR_VAL=0x6 -> Busy high 32 cycles; a Write attempted during Busy is dropped. All reads afterwards return 0x6.
- Assert Clear again while ClrAddr=12 -> ClrAddr returns to 0 and Busy lasts 32 further cycles. Pull Resetn low at ClrAddr=7 -> DataOut=0, Valid=0, ClrAddr=0 asynchronously, and the clear restarts after release.
- DEPTH=20, ADDR_W=5: Write 0x5 to address 25 is dropped. Read of address 25 -> DataOut=CLEAR_VAL with Valid=1. Read of address 19 after writing 0x9 -> 0x9.
